// File: rtl/pre_spike_history_if.sv
// Spike-event, clear-sweep and read-port bundle for the pre-neuron spike-history store.
interface pre_spike_history_if #(
    parameter int TIME_STEP = 8,
    parameter int ADDR_W    = 8,
    parameter int TS_W      = $clog2(TIME_STEP),
    parameter int CNT_W     = $clog2(TIME_STEP + 1)
);
    logic                 ev_valid;
    logic                 ev_ready;
    logic [ADDR_W-1:0]    ev_addr;
    logic [TS_W-1:0]      ev_time_step;
    logic                 ref_start;
    logic                 ref_busy;
    logic                 ref_done;
    logic                 rd_valid;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_data_valid;
    logic [TIME_STEP-1:0] rd_bitmap;
    logic [CNT_W-1:0]     rd_count;
    logic [TS_W-1:0]      rd_first_step;
    logic                 rd_any;
    logic                 err_ts;

    modport master (
        output ev_valid, ev_addr, ev_time_step, ref_start, rd_valid, rd_addr,
        input  ev_ready, ref_busy, ref_done, rd_data_valid, rd_bitmap,
               rd_count, rd_first_step, rd_any, err_ts
    );

    modport slave (
        input  ev_valid, ev_addr, ev_time_step, ref_start, rd_valid, rd_addr,
        output ev_ready, ref_busy, ref_done, rd_data_valid, rd_bitmap,
               rd_count, rd_first_step, rd_any, err_ts
    );
endinterface

// File: rtl/pre_spike_history.sv
// Per-pre-neuron spike-history bitmaps with write-through read port and a row-per-cycle clear sweep.
//   state | meaning
//   IDLE  | accepting spike events
//   CLEAR | zeroing row clr_ptr each cycle, events blocked
module pre_spike_history #(
    parameter int N_PRE     = 256,
    parameter int TIME_STEP = 8,
    parameter int ADDR_W    = $clog2(N_PRE),
    parameter int TS_W      = $clog2(TIME_STEP),
    parameter int CNT_W     = $clog2(TIME_STEP + 1)
) (
    input logic                clk,
    input logic                rst_n,
    pre_spike_history_if.slave bus
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state, state_nxt;
    logic [ADDR_W-1:0]    clr_ptr;
    logic [TIME_STEP-1:0] mem [N_PRE];
    logic                 ev_acc;
    logic                 clr_last;
    logic [TIME_STEP-1:0] ev_onehot;
    logic [TIME_STEP-1:0] rd_row;
    logic [CNT_W-1:0]     rd_cnt_nxt;
    logic [TS_W-1:0]      rd_first_nxt;

    assign ev_acc   = bus.ev_valid & bus.ev_ready;
    assign clr_last = (clr_ptr == ADDR_W'(N_PRE - 1));

    // An out-of-range step decodes to all-zero, so the OR-write leaves the row untouched.
    always_comb begin
        ev_onehot = '0;
        for (int k = 0; k < TIME_STEP; k++)
            ev_onehot[k] = (bus.ev_time_step == TS_W'(k));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.ref_start) state_nxt = CLEAR;
            CLEAR:   if (clr_last)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ev_ready = (state == IDLE);
        bus.ref_busy = (state == CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              clr_ptr <= '0;
        else if (state == IDLE)  clr_ptr <= '0;
        else                     clr_ptr <= clr_ptr + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PRE; i++) mem[i] <= '0;
        end else if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (ev_acc) begin
            mem[bus.ev_addr] <= mem[bus.ev_addr] | ev_onehot;
        end
    end

    // Same-edge event to the row being read is folded in before registering.
    always_comb begin
        rd_row = mem[bus.rd_addr];
        if (ev_acc && (bus.ev_addr == bus.rd_addr))
            rd_row = rd_row | ev_onehot;
        rd_cnt_nxt = '0;
        for (int k = 0; k < TIME_STEP; k++)
            rd_cnt_nxt = rd_cnt_nxt + CNT_W'(rd_row[k]);
        rd_first_nxt = '0;
        for (int k = TIME_STEP - 1; k >= 0; k--)
            if (rd_row[k]) rd_first_nxt = TS_W'(k);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ref_done      <= 1'b0;
            bus.rd_data_valid <= 1'b0;
            bus.rd_bitmap     <= '0;
            bus.rd_count      <= '0;
            bus.rd_first_step <= '0;
            bus.rd_any        <= 1'b0;
            bus.err_ts        <= 1'b0;
        end else begin
            bus.ref_done      <= (state == CLEAR) && clr_last;
            bus.rd_data_valid <= bus.rd_valid;
            if (bus.rd_valid) begin
                bus.rd_bitmap     <= rd_row;
                bus.rd_count      <= rd_cnt_nxt;
                bus.rd_first_step <= rd_first_nxt;
                bus.rd_any        <= |rd_row;
            end
            if (ev_acc && (ev_onehot == '0))
                bus.err_ts <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pre_spike_history.sv
// Directed plus randomized bench for pre_spike_history against an array-based history model.
module tb_pre_spike_history;
    localparam int N_PRE     = 256;
    localparam int TIME_STEP = 8;
    localparam int ADDR_W    = 8;
    localparam int TS_W      = 4;   // one spare bit so out-of-range steps can be driven
    localparam int CNT_W     = 4;

    logic clk;
    logic rst_n;

    pre_spike_history_if #(.TIME_STEP(TIME_STEP), .ADDR_W(ADDR_W), .TS_W(TS_W), .CNT_W(CNT_W)) bus();

    pre_spike_history #(
        .N_PRE(N_PRE), .TIME_STEP(TIME_STEP), .ADDR_W(ADDR_W), .TS_W(TS_W), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    logic [TIME_STEP-1:0] model [N_PRE];
    logic [TIME_STEP-1:0] snap  [N_PRE];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_set(input logic [TIME_STEP-1:0] row);
        for (int k = 0; k < TIME_STEP; k++)
            if (row[k]) return k;
        return 0;
    endfunction

    task automatic check_read(input string tag, input logic [TIME_STEP-1:0] exp);
        chk({tag, ".valid"},  32'(bus.rd_data_valid), 32'(1));
        chk({tag, ".bitmap"}, 32'(bus.rd_bitmap),     32'(exp));
        chk({tag, ".count"},  32'(bus.rd_count),      32'($countones(exp)));
        chk({tag, ".first"},  32'(bus.rd_first_step), 32'(first_set(exp)));
        chk({tag, ".any"},    32'(bus.rd_any),        32'(exp != '0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ev_valid     = 1'b0;
        bus.ev_addr      = '0;
        bus.ev_time_step = '0;
        bus.ref_start    = 1'b0;
        bus.rd_valid     = 1'b0;
        bus.rd_addr      = '0;
    endtask

    task automatic do_event(input int a, input int ts);
        bus.ev_valid     = 1'b1;
        bus.ev_addr      = ADDR_W'(a);
        bus.ev_time_step = TS_W'(ts);
        if (ts < TIME_STEP) model[a] = model[a] | (TIME_STEP'(1) << ts);
        step();
        bus.ev_valid = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int r = 0; r < N_PRE; r++) begin
            bus.rd_valid = 1'b1;
            bus.rd_addr  = ADDR_W'(r);
            step();
            check_read(tag, model[r]);
        end
        bus.rd_valid = 1'b0;
    endtask

    initial begin
        logic [TIME_STEP-1:0] last_bm;
        logic [TIME_STEP-1:0] exp_rd;
        int busy_cnt, ready_bad, done_cnt, done_at;

        rst_n = 1'b0;
        idle_inputs();
        for (int i = 0; i < N_PRE; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ev_ready",  32'(bus.ev_ready),      32'(1));
        chk("rst.ref_busy",  32'(bus.ref_busy),      32'(0));
        chk("rst.ref_done",  32'(bus.ref_done),      32'(0));
        chk("rst.rd_dv",     32'(bus.rd_data_valid), 32'(0));
        chk("rst.bitmap",    32'(bus.rd_bitmap),     32'(0));
        chk("rst.count",     32'(bus.rd_count),      32'(0));
        chk("rst.first",     32'(bus.rd_first_step), 32'(0));
        chk("rst.any",       32'(bus.rd_any),        32'(0));
        chk("rst.err_ts",    32'(bus.err_ts),        32'(0));
        rst_n = 1'b1;
        step();

        bus.rd_valid = 1'b1; bus.rd_addr = 8'd5;
        step();
        check_read("rd5", 8'h00);
        bus.rd_valid = 1'b0;
        step();
        chk("rd5.dv_drop", 32'(bus.rd_data_valid), 32'(0));

        do_event(3, 2);
        do_event(3, 5);
        do_event(3, 2);
        bus.rd_valid = 1'b1; bus.rd_addr = 8'd3;
        step();
        check_read("rd3", 8'b0010_0100);

        bus.ev_valid = 1'b1; bus.ev_addr = 8'd7; bus.ev_time_step = 4'd0;
        bus.rd_addr = 8'd7;
        model[7] = model[7] | 8'h01;
        step();
        check_read("bypass7", 8'b0000_0001);
        last_bm = 8'h01;
        idle_inputs();

        for (int it = 0; it < 400; it++) begin
            int a, ts, ra;
            logic ev, rv;
            ev = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            a  = int'($urandom_range(0, 15));
            ts = int'($urandom_range(0, TIME_STEP - 1));
            ra = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 15));
            bus.ev_valid     = ev;
            bus.ev_addr      = ADDR_W'(a);
            bus.ev_time_step = TS_W'(ts);
            bus.rd_valid     = rv;
            bus.rd_addr      = ADDR_W'(ra);
            if (ev) model[a] = model[a] | (TIME_STEP'(1) << ts);
            exp_rd = model[ra];
            step();
            if (rv) begin
                check_read("rand", exp_rd);
                last_bm = exp_rd;
            end else begin
                chk("rand.no_dv", 32'(bus.rd_data_valid), 32'(0));
                chk("rand.hold",  32'(bus.rd_bitmap),     32'(last_bm));
            end
        end
        idle_inputs();
        step();
        chk("err_ts.clean", 32'(bus.err_ts), 32'(0));

        for (int r = 0; r < N_PRE - 1; r++) do_event(r, 1);
        bus.ev_valid = 1'b1; bus.ev_addr = 8'd255; bus.ev_time_step = 4'd1;
        bus.ref_start = 1'b1;
        bus.rd_valid = 1'b1; bus.rd_addr = 8'd255;
        model[255] = model[255] | 8'h02;
        snap = model;
        step();
        check_read("start.bypass255", snap[255]);
        idle_inputs();
        busy_cnt  = bus.ref_busy ? 1 : 0;
        ready_bad = (bus.ev_ready === bus.ref_busy) ? 1 : 0;
        done_cnt  = bus.ref_done ? 1 : 0;
        done_at   = bus.ref_done ? 0 : -1;
        for (int j = 1; j <= 260; j++) begin
            bus.ev_valid     = (j < 256);
            bus.ev_addr      = ADDR_W'($urandom_range(0, N_PRE - 1));
            bus.ev_time_step = 4'd3;
            bus.ref_start    = (j == 50);
            bus.rd_valid     = (j == 101);
            bus.rd_addr      = 8'd200;
            step();
            if (bus.ref_busy) busy_cnt++;
            if (bus.ev_ready === bus.ref_busy) ready_bad++;
            if (bus.ref_done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (j == 101) check_read("sweep.rd200", snap[200]);
        end
        idle_inputs();
        chk("sweep.busy_cycles", 32'(busy_cnt),  32'(N_PRE));
        chk("sweep.ready_inv",   32'(ready_bad), 32'(0));
        chk("sweep.done_count",  32'(done_cnt),  32'(1));
        chk("sweep.done_cycle",  32'(done_at),   32'(N_PRE));
        for (int i = 0; i < N_PRE; i++) model[i] = '0;
        read_all("post_sweep");

        do_event(9, 8);
        chk("err_ts.set", 32'(bus.err_ts), 32'(1));
        repeat (5) step();
        chk("err_ts.sticky", 32'(bus.err_ts),   32'(1));
        chk("err_ts.ready",  32'(bus.ev_ready), 32'(1));
        bus.rd_valid = 1'b1; bus.rd_addr = 8'd9;
        step();
        check_read("err_ts.rd9", model[9]);
        idle_inputs();

        for (int i = 0; i < 20; i++)
            do_event(int'($urandom_range(0, N_PRE - 1)), int'($urandom_range(0, TIME_STEP - 1)));
        bus.ref_start = 1'b1;
        step();
        bus.ref_start = 1'b0;
        repeat (50) step();
        chk("abort.busy_before", 32'(bus.ref_busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("abort.busy_async",  32'(bus.ref_busy), 32'(0));
        chk("abort.ready_async", 32'(bus.ev_ready), 32'(1));
        chk("abort.err_async",   32'(bus.err_ts),   32'(0));
        step();
        rst_n = 1'b1;
        for (int i = 0; i < N_PRE; i++) model[i] = '0;
        step();
        chk("abort.ready_after", 32'(bus.ev_ready), 32'(1));
        chk("abort.busy_after",  32'(bus.ref_busy), 32'(0));
        read_all("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pre_spike_history.md
Name: pre_spike_history

Overview:
- Per-presynaptic-neuron spike-history store for the FF-STDP core.
- Records, for every pre-neuron, a TIME_STEP-bit one-hot-accumulated bitmap of the time steps in which it spiked.
- Provides a registered read port returning the bitmap, spike count and earliest spike step, consumed by the weight-update stage.
- Clears all histories on a time-reference event via a sequenced sweep FSM.

Parameters:
- N_PRE, 256, number of presynaptic neurons tracked.
- TIME_STEP, 8, time steps per reference window; bitmap width.
- ADDR_W, clog2(N_PRE), neuron address width.
- TS_W, clog2(TIME_STEP), time-step index width.
- CNT_W, clog2(TIME_STEP+1), spike-count width.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  asynchronous active-low reset.
- ev_valid  in  1  spike event valid.
- ev_ready  out  1  block can accept an event.
- ev_addr  in  ADDR_W  spiking pre-neuron.
- ev_time_step  in  TS_W  current time step of the event.
- ref_start  in  1  time-reference pulse: clear all histories.
- ref_busy  out  1  clear sweep in progress.
- ref_done  out  1  one-cycle pulse when the sweep completes.
- rd_valid  in  1  read request.
- rd_addr  in  ADDR_W  neuron to read.
- rd_data_valid  out  1  read data valid (one cycle).
- rd_bitmap  out  TIME_STEP  history bitmap, bit k = spiked at step k.
- rd_count  out  CNT_W  popcount of rd_bitmap.
- rd_first_step  out  TS_W  index of lowest set bit; 0 if none.
- rd_any  out  1  rd_bitmap nonzero.
- err_ts  out  1  sticky: an event arrived with ev_time_step >= TIME_STEP.

Behaviour:
- Storage: N_PRE x TIME_STEP flop array.
- Reset (RST_N low, async): whole array is 0; FSM = IDLE; ev_ready=1; ref_busy=0; ref_done=0; rd_data_valid=0; rd_bitmap/rd_count/rd_first_step/rd_any=0; err_ts=0.
- FSM states:
  - IDLE: ev_ready=1.
  - CLEAR: ev_ready=0, ref_busy=1, sweep pointer clr_ptr.
- IDLE -> CLEAR on ref_start. clr_ptr=0 on entry.
- In CLEAR, one row is zeroed per cycle: row clr_ptr at each edge, then clr_ptr+1.
- When the edge clears row N_PRE-1: go to IDLE and pulse ref_done in the following cycle.
- Sweep length is exactly N_PRE cycles. ref_start during CLEAR is ignored (no restart).
- Event accept: ev_valid & ev_ready at a rising edge. The row for ev_addr becomes row | (1 << ev_time_step) at that edge.
- Repeated events for the same neuron and step are idempotent.
- Events with ev_time_step >= TIME_STEP are accepted and dropped (row unchanged), and set err_ts. err_ts clears only on reset.
- ref_start and an accepted event in the same IDLE cycle: the event is written first, then the sweep starts. The written row is cleared when the sweep reaches it.
- Read: rd_valid sampled at edge t; outputs registered and valid at t+1 with rd_data_valid=1 for one cycle.
- Read data includes any event accepted at the same edge t (write-through bypass) and excludes clears not yet swept.
- Reads are allowed in any state. During CLEAR, rows with index < clr_ptr read 0 and others read their old contents.
- With no read, rd_data_valid=0 and the data outputs hold their last value.
- Back-to-back reads: one result per cycle, fully pipelined.
- rd_count range 0..TIME_STEP, no saturation needed. rd_first_step uses a priority encoder, LSB first.
- ref_busy is combinationally equal to (state==CLEAR).
- RST_N asserted mid-sweep aborts the sweep and zeroes all state immediately.

Test Plan:
- Reset then read addr 5 -> one cycle later rd_data_valid=1, rd_bitmap=0, rd_count=0, rd_any=0, rd_first_step=0.
- Events (addr 3, ts 2), (3, 5), (3, 2) -> read 3 gives rd_bitmap=8'b0010_0100, rd_count=2, rd_first_step=2, rd_any=1.
- Event (7, 0) and read 7 in the same cycle -> next cycle rd_bitmap=8'b0000_0001 (bypass).
- Fill rows 0..255 with ts 1, pulse ref_start:
  - ref_busy=1 and ev_ready=0 for exactly 256 cycles; ref_done pulses once.
  - A read of row 200 while clr_ptr=100 returns 8'b0000_0010.
  - After completion, all rows read 0.
- Event (9, ts=8) with TIME_STEP=8 -> err_ts=1 and stays 1; read 9 returns 0.
- RST_N low at clr_ptr=50 -> ref_busy=0 immediately; after release, all rows read 0 and ev_ready=1.
